// File: rtl/seq_magnitude_comparator_pkg.sv
// Shared types and constants for the digit-serial magnitude comparator.
// The state encoding lives here so the top and any observers agree on it.
package seq_magnitude_comparator_pkg;

  localparam int DIGIT_BITS = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    DONE    = 2'd2
  } state_t;

  // Width of the digit counter for a given operand width; one spare bit so
  // the load value WIDTH/DIGIT_BITS always fits.
  function automatic int cnt_width(input int width);
    return $clog2(width / DIGIT_BITS) + 1;
  endfunction

endpackage

// File: rtl/seq_magnitude_comparator_if.sv
// Start/done handshake plus operand and result bundle of the comparator.
// master drives the request, slave is the comparator itself.
interface seq_magnitude_comparator_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             lt;
  logic             eq;
  logic             gt;

  modport master (
    output start, a, b,
    input  busy, done, lt, eq, gt
  );

  modport slave (
    input  start, a, b,
    output busy, done, lt, eq, gt
  );

endinterface

// File: rtl/seq_magnitude_comparator_comparator_2bit.sv
// Combinational 2-bit unsigned comparator cell; exactly one of lt/eq/gt is high.
module comparator_2bit
  import seq_magnitude_comparator_pkg::*;
(
  input  logic [DIGIT_BITS-1:0] a,
  input  logic [DIGIT_BITS-1:0] b,
  output logic                  lt,
  output logic                  eq,
  output logic                  gt
);

  logic [DIGIT_BITS-1:0] bit_eq;

  generate
    for (genvar gi = 0; gi < DIGIT_BITS; gi++) begin : g_bit_eq
      assign bit_eq[gi] = ~(a[gi] ^ b[gi]);
    end
  endgenerate

  // The upper bit decides unless it ties, then the lower bit decides.
  assign eq = &bit_eq;
  assign gt = (a[1] & ~b[1]) | (bit_eq[1] & a[0] & ~b[0]);
  assign lt = ~eq & ~gt;

endmodule

// File: rtl/seq_magnitude_comparator.sv
// Digit-serial unsigned magnitude comparator: scans MSB-first, two bits per
// clock, and stops at the first unequal digit pair.
module seq_magnitude_comparator
  import seq_magnitude_comparator_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  seq_magnitude_comparator_if.slave  bus
);

  localparam int                CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(WIDTH / DIGIT_BITS);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(1);

  generate
    if (WIDTH < DIGIT_BITS || (WIDTH % DIGIT_BITS) != 0) begin : g_bad_width
      $error("seq_magnitude_comparator: WIDTH must be even and >= 2");
    end
  endgenerate

  state_t             state_reg, state_next;
  logic [WIDTH-1:0]   sa_reg, sa_next;
  logic [WIDTH-1:0]   sb_reg, sb_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               lt_reg, lt_next;
  logic               eq_reg, eq_next;
  logic               gt_reg, gt_next;

  logic               cell_lt, cell_eq, cell_gt;

  comparator_2bit u_cell (
    .a  (sa_reg[WIDTH-1 -: DIGIT_BITS]),
    .b  (sb_reg[WIDTH-1 -: DIGIT_BITS]),
    .lt (cell_lt),
    .eq (cell_eq),
    .gt (cell_gt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      sa_reg    <= '0;
      sb_reg    <= '0;
      cnt_reg   <= '0;
      lt_reg    <= 1'b0;
      eq_reg    <= 1'b0;
      gt_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      sa_reg    <= sa_next;
      sb_reg    <= sb_next;
      cnt_reg   <= cnt_next;
      lt_reg    <= lt_next;
      eq_reg    <= eq_next;
      gt_reg    <= gt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    sa_next    = sa_reg;
    sb_next    = sb_reg;
    cnt_next   = cnt_reg;
    lt_next    = lt_reg;
    eq_next    = eq_reg;
    gt_next    = gt_reg;

    unique case (state_reg)
      IDLE: begin
        if (bus.start) begin
          sa_next    = bus.a;
          sb_next    = bus.b;
          cnt_next   = CNT_LOAD;
          lt_next    = 1'b0;
          eq_next    = 1'b0;
          gt_next    = 1'b0;
          state_next = COMPARE;
        end
      end

      COMPARE: begin
        if (!cell_eq) begin
          lt_next    = cell_lt;
          gt_next    = cell_gt;
          eq_next    = 1'b0;
          state_next = DONE;
        end else if (cnt_reg == CNT_LAST) begin
          // Last digit tied: checked before the decrement so cnt never wraps.
          eq_next    = 1'b1;
          state_next = DONE;
        end else begin
          sa_next  = sa_reg << DIGIT_BITS;
          sb_next  = sb_reg << DIGIT_BITS;
          cnt_next = cnt_reg - CNT_LAST;
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.busy = (state_reg != IDLE);
  assign bus.done = (state_reg == DONE);
  assign bus.lt   = lt_reg;
  assign bus.eq   = eq_reg;
  assign bus.gt   = gt_reg;

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Randomised self-checking bench for seq_magnitude_comparator at WIDTH=8 and WIDTH=2.
module tb_seq_magnitude_comparator;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  seq_magnitude_comparator_if #(.WIDTH(8)) i8 ();
  seq_magnitude_comparator_if #(.WIDTH(2)) i2 ();

  seq_magnitude_comparator #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(i8));
  seq_magnitude_comparator #(.WIDTH(2)) dut2 (.clk(clk), .rst(rst), .bus(i2));

  // Reference: result from integer compare, latency from digit-by-digit arithmetic.
  function automatic logic [2:0] ref_res(input int av, input int bv);
    if (av < bv)       return 3'b100;
    else if (av == bv) return 3'b010;
    else               return 3'b001;
  endfunction

  function automatic int ref_k(input int av, input int bv, input int width);
    for (int i = 1; i <= width / 2; i++) begin
      if (((av >> (width - 2 * i)) % 4) != ((bv >> (width - 2 * i)) % 4)) return i;
    end
    return width / 2;
  endfunction

  // Issues one compare on the 8-bit instance and reports what was observed.
  // Cycle n is the n-th cycle after the accepting edge.
  task automatic run8(input logic [7:0] av, input logic [7:0] bv, input bit noise,
                      output int done_cyc, output int pulses, output int busy_cyc,
                      output logic [2:0] res, output logic [2:0] held,
                      output bit inflight_clean);
    done_cyc = -1; pulses = 0; busy_cyc = 0; inflight_clean = 1'b1;
    res = 3'b000; held = 3'b000;
    @(posedge clk); #1;
    i8.start = 1'b1; i8.a = av; i8.b = bv;
    @(posedge clk); #1;
    if (noise) begin
      i8.start = 1'b1; i8.a = ~av; i8.b = ~bv;
    end else begin
      i8.start = 1'b0; i8.a = 8'($urandom); i8.b = 8'($urandom);
    end
    for (int n = 1; n <= 14; n++) begin
      if (i8.busy) busy_cyc++;
      if (i8.done) begin
        pulses++;
        if (done_cyc < 0) begin
          done_cyc = n;
          res = {i8.lt, i8.eq, i8.gt};
        end
      end else if (i8.busy && (i8.lt || i8.eq || i8.gt)) begin
        inflight_clean = 1'b0;
      end
      if (!i8.busy) begin
        i8.start = 1'b0;
        if (done_cyc > 0 && n == done_cyc + 1) held = {i8.lt, i8.eq, i8.gt};
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    i8.start = 1'b0; i8.a = '0; i8.b = '0;
    i2.start = 1'b0; i2.a = '0; i2.b = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({i8.busy, i8.done, i8.lt, i8.eq, i8.gt} !== 5'b0) begin
      errors++;
      $display("FAIL reset8: got %b expected 00000", {i8.busy, i8.done, i8.lt, i8.eq, i8.gt});
    end
    checks++;
    if ({i2.busy, i2.done, i2.lt, i2.eq, i2.gt} !== 5'b0) begin
      errors++;
      $display("FAIL reset2: got %b expected 00000", {i2.busy, i2.done, i2.lt, i2.eq, i2.gt});
    end
    rst = 1'b0;
    $display("reset: outputs %b / %b", {i8.busy, i8.done, i8.lt, i8.eq, i8.gt},
             {i2.busy, i2.done, i2.lt, i2.eq, i2.gt});
  endtask

  task automatic test_directed();
    logic [7:0] av_tab [3] = '{8'hA5, 8'h80, 8'h12};
    logic [7:0] bv_tab [3] = '{8'hA5, 8'h7F, 8'h13};
    int dc, pl, bc; logic [2:0] r, h; bit clean;
    for (int t = 0; t < 3; t++) begin
      int k = ref_k(int'(av_tab[t]), int'(bv_tab[t]), 8);
      logic [2:0] exp_r = ref_res(int'(av_tab[t]), int'(bv_tab[t]));
      run8(av_tab[t], bv_tab[t], 1'b0, dc, pl, bc, r, h, clean);
      $display("directed a=%h b=%h: done_cycle=%0d busy=%0d res=%b", av_tab[t], bv_tab[t], dc, bc, r);
      checks++;
      if (dc !== k + 1) begin errors++; $display("FAIL dir_latency: got %0d expected %0d", dc, k + 1); end
      checks++;
      if (bc !== k + 1) begin errors++; $display("FAIL dir_busy: got %0d expected %0d", bc, k + 1); end
      checks++;
      if (r !== exp_r) begin errors++; $display("FAIL dir_result: got %b expected %b", r, exp_r); end
      checks++;
      if (h !== exp_r) begin errors++; $display("FAIL dir_hold: got %b expected %b", h, exp_r); end
      checks++;
      if (pl !== 1 || !clean) begin
        errors++; $display("FAIL dir_pulse: pulses %0d clean %0d expected 1 1", pl, clean);
      end
    end
    checks++;
    if ({i8.lt, i8.eq, i8.gt} !== 3'b100) begin
      errors++; $display("FAIL idle_hold: got %b expected 100", {i8.lt, i8.eq, i8.gt});
    end
  endtask

  task automatic test_start_while_busy();
    int dc, pl, bc; logic [2:0] r, h; bit clean;
    run8(8'h00, 8'hFF, 1'b1, dc, pl, bc, r, h, clean);
    $display("busy_start a=00 b=ff: done_cycle=%0d pulses=%0d res=%b", dc, pl, r);
    checks++;
    if (pl !== 1) begin errors++; $display("FAIL busy_pulses: got %0d expected 1", pl); end
    checks++;
    if (r !== 3'b100 || dc !== 2) begin
      errors++; $display("FAIL busy_result: got %b at %0d expected 100 at 2", r, dc);
    end
    run8(8'hFF, 8'h00, 1'b0, dc, pl, bc, r, h, clean);
    $display("after_busy a=ff b=00: done_cycle=%0d res=%b", dc, r);
    checks++;
    if (r !== 3'b001 || dc !== 2) begin
      errors++; $display("FAIL busy_next: got %b at %0d expected 001 at 2", r, dc);
    end
  endtask

  task automatic test_reset_midop();
    int pulses = 0;
    @(posedge clk); #1;
    i8.start = 1'b1; i8.a = 8'h55; i8.b = 8'h55;
    @(posedge clk); #1;
    i8.start = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (i8.busy !== 1'b1) begin errors++; $display("FAIL midop_busy: got %b expected 1", i8.busy); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if ({i8.busy, i8.done, i8.lt, i8.eq, i8.gt} !== 5'b0) begin
      errors++; $display("FAIL midop_clear: got %b expected 00000", {i8.busy, i8.done, i8.lt, i8.eq, i8.gt});
    end
    for (int n = 0; n < 8; n++) begin
      if (i8.done) pulses++;
      @(posedge clk); #1;
    end
    checks++;
    if (pulses !== 0) begin errors++; $display("FAIL midop_nodone: got %0d expected 0", pulses); end
    $display("reset_midop: late done pulses=%0d", pulses);
    // Reset and start on the same edge: start is dropped.
    rst = 1'b1; i8.start = 1'b1; i8.a = 8'h01; i8.b = 8'h02;
    @(posedge clk); #1;
    rst = 1'b0; i8.start = 1'b0;
    checks++;
    if (i8.busy !== 1'b0) begin errors++; $display("FAIL rst_start: busy %b expected 0", i8.busy); end
    $display("rst_with_start: busy=%b", i8.busy);
  endtask

  task automatic test_random8();
    int dc, pl, bc; logic [2:0] r, h; bit clean;
    for (int t = 0; t < 30; t++) begin
      logic [7:0] av = 8'($urandom);
      logic [7:0] bv;
      int mode = int'($urandom_range(0, 2));
      int k; logic [2:0] exp_r;
      if (mode == 0) bv = av;
      else if (mode == 1) bv = av ^ (8'($urandom_range(1, 3)) << (2 * $urandom_range(0, 3)));
      else bv = 8'($urandom);
      k = ref_k(int'(av), int'(bv), 8);
      exp_r = ref_res(int'(av), int'(bv));
      run8(av, bv, 1'b0, dc, pl, bc, r, h, clean);
      $display("rand8 a=%h b=%h: done_cycle=%0d res=%b", av, bv, dc, r);
      checks++;
      if (dc !== k + 1 || r !== exp_r || pl !== 1 || !clean) begin
        errors++;
        $display("FAIL rand8: got cyc %0d res %b pulses %0d clean %0d expected cyc %0d res %b pulses 1 clean 1",
                 dc, r, pl, clean, k + 1, exp_r);
      end
    end
  endtask

  task automatic test_min_width();
    for (int t = 0; t < 36; t++) begin
      logic [1:0] av = (t < 16) ? 2'(t / 4) : 2'($urandom);
      logic [1:0] bv = (t < 16) ? 2'(t % 4) : 2'($urandom);
      logic [2:0] exp_r = ref_res(int'(av), int'(bv));
      logic [1:0] seen;
      logic [2:0] r;
      @(posedge clk); #1;
      i2.start = 1'b1; i2.a = av; i2.b = bv;
      @(posedge clk); #1;
      i2.start = 1'b0; i2.a = 2'($urandom); i2.b = 2'($urandom);
      seen[0] = i2.done;
      checks++;
      if (i2.busy !== 1'b1) begin errors++; $display("FAIL w2_busy: got %b expected 1", i2.busy); end
      @(posedge clk); #1;
      seen[1] = i2.done;
      r = {i2.lt, i2.eq, i2.gt};
      $display("w2 a=%0d b=%0d: done_by_cycle=%b res=%b", av, bv, seen, r);
      checks++;
      if (seen !== 2'b10 || r !== exp_r) begin
        errors++;
        $display("FAIL w2_compare: got done %b res %b expected done 10 res %b", seen, r, exp_r);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_start_while_busy();
    test_reset_midop();
    test_random8();
    test_min_width();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_magnitude_comparator.md
Name: seq_magnitude_comparator

Overview:
Multi-cycle unsigned magnitude comparator for WIDTH-bit operands. It scans the operands MSB-first, one 2-bit digit pair per clock, through a single 2-bit comparator cell, and terminates early at the first unequal digit. It uses a start/done handshake and is intended for width-scalable compare paths where area matters more than latency.

Parameters:
WIDTH, 8, operand width in bits; must be even and >= 2 (elaboration error otherwise)

Ports:
clk  input  1  rising-edge clock, single clock domain
rst  input  1  reset, synchronous, active-high
start  input  1  request a compare; accepted only in IDLE
a  input  WIDTH  operand A, unsigned; sampled on the accepting edge only
b  input  WIDTH  operand B, unsigned; sampled on the accepting edge only
busy  output  1  high in COMPARE and DONE
done  output  1  one-cycle pulse, result valid
lt  output  1  A < B
eq  output  1  A == B
gt  output  1  A > B

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE; busy, done, lt, eq, gt all 0; shift registers and digit counter cleared.
- Reset has priority over all other inputs and also applies mid-operation: the compare is aborted, no done pulse is produced, and the outputs are 0 on the next cycle.
- States: IDLE, COMPARE, DONE; encoding is defined in the package.
- IDLE:
  - On start=1: latch a and b into shift registers sa and sb.
  - Load digit counter cnt = WIDTH/2.
  - Clear lt/eq/gt to 0 and go to COMPARE.
  - On start=0: hold state; lt/eq/gt keep the last result.
- COMPARE, each cycle:
  - The cell compares sa[WIDTH-1:WIDTH-2] against sb[WIDTH-1:WIDTH-2].
  - If the cell reports lt or gt: register that result (eq=0) and go to DONE.
  - Else, if cnt==1: register eq=1 and go to DONE.
  - Else: shift sa and sb left by 2, decrement cnt, and stay in COMPARE.
- DONE: done=1 for exactly one cycle, then go to IDLE unconditionally.
- Latency:
  - k = 1-based index of the first unequal digit pair, counted from the MSB; k = WIDTH/2 when A==B.
  - Measured from the start-accepting edge, done is high in cycle k+1.
  - Next start can be accepted 1 cycle after done, i.e. throughput is one compare per k+2 cycles.
- Outputs are registered and one-hot after a completed compare.
  - They hold their value through IDLE until the next start is accepted.
  - All three are 0 after reset and while a compare is in flight.
- start while busy=1 (COMPARE or DONE) is ignored: no queueing and no effect on the operation in flight.
- a and b changes after the accepting edge have no effect.
- Simultaneous rst and start: reset wins and start is dropped.
- The cnt width is $clog2(WIDTH/2)+1. cnt must never wrap: the cnt==1 exit takes precedence over the decrement.

Decomposition:
- Shared package: state enum (IDLE=2'd0, COMPARE=2'd1, DONE=2'd2) and the DIGIT_BITS=2 constant.
- Sub-module: comparator_2bit, the existing 2-bit comparator cell, instanced once as the per-cycle digit comparator. Its inputs are the top digits of sa/sb; its lt/eq/gt outputs feed the FSM.
- Everything else (FSM, shift registers, counter, result registers) lives in this module.

Test Plan:
All scenarios use WIDTH=8 unless noted.
- Equal operands: a=8'hA5, b=8'hA5, start pulse -> busy high for 5 cycles; done in cycle 5 after the accept edge; eq=1, lt=0, gt=0, held afterwards.
- Early exit on first digit: a=8'h80, b=8'h7F -> done in cycle 2; gt=1, lt=0, eq=0.
- Difference in last digit: a=8'h12, b=8'h13 -> done in cycle 5; lt=1, others 0.
- Start while busy: start a=8'h00, b=8'hFF; assert start with a=8'hFF, b=8'h00 during COMPARE and again during DONE -> one done pulse only, with lt=1; a new start in IDLE then gives gt=1.
- Reset mid-operation: a=8'h55, b=8'h55 and assert rst in the 2nd COMPARE cycle -> next cycle busy=0, done=0, lt/eq/gt=0; no done pulse follows.
- Minimum width: WIDTH=2, sweep all 16 (a,b) pairs -> done always in cycle 2; the one-hot result matches an integer compare (random back-to-back starts included).
